// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for pipe_stage_reg: upstream (in_*), downstream (out_*),
// flush and the stall counter, grouped so one port carries the whole stage.
// master = the surrounding pipeline/test driver, slave = the stage register.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 48,
   parameter int CTRL_W = 7,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output in_valid, in_data, in_ctrl, flush, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl, stall_cnt
   );

   modport slave (
      input  in_valid, in_data, in_ctrl, flush, out_ready,
      output in_ready, out_valid, out_data, out_ctrl, stall_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline-stage register with valid/ready flow control, flush and
// bubble-safe control gating (out_ctrl forced to zero whenever out_valid=0).
// Build option: PIPE_STAGE_SKID_EN adds a skid entry so in_ready comes from a
// register (no combinational out_ready -> in_ready path). Without it the stage
// holds a single entry and in_ready = ~mv | out_ready.
module pipe_stage_reg #(
   parameter int DATA_W = 48,
   parameter int CTRL_W = 7,
   parameter int CNT_W  = 16
) (
   input logic            clk,
   input logic            rst_n,
   pipe_stage_reg_if.slave bus
);

   logic              r_mv;
   logic [DATA_W-1:0] r_mdata;
   logic [CTRL_W-1:0] r_mctrl;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_in_ready;
   logic w_accept;
   logic w_drain;
   logic w_stall;

   assign w_accept = bus.in_valid & w_in_ready;
   assign w_drain  = r_mv & bus.out_ready;
   assign w_stall  = r_mv & ~bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              r_sv;
   logic [DATA_W-1:0] r_sdata;
   logic [CTRL_W-1:0] r_sctrl;

   // Skid entry is a register, so in_ready never depends on out_ready.
   assign w_in_ready = ~r_sv;

   // Main entry: refill from skid first, otherwise from the input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mv    <= 1'b0;
         r_mdata <= '0;
         r_mctrl <= '0;
      end else if (bus.flush) begin
         r_mv <= 1'b0;
      end else if (!r_mv) begin
         if (w_accept) begin
            r_mv    <= 1'b1;
            r_mdata <= bus.in_data;
            r_mctrl <= bus.in_ctrl;
         end
      end else if (w_drain) begin
         if (r_sv) begin
            r_mdata <= r_sdata;
            r_mctrl <= r_sctrl;
         end else if (w_accept) begin
            r_mdata <= bus.in_data;
            r_mctrl <= bus.in_ctrl;
         end else begin
            r_mv <= 1'b0;
         end
      end
   end

   // Skid entry: catches the input when main is held by back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sv    <= 1'b0;
         r_sdata <= '0;
         r_sctrl <= '0;
      end else if (bus.flush) begin
         r_sv <= 1'b0;
      end else if (w_drain && r_sv) begin
         r_sv <= 1'b0;
      end else if (r_mv && !w_drain && w_accept) begin
         r_sv    <= 1'b1;
         r_sdata <= bus.in_data;
         r_sctrl <= bus.in_ctrl;
      end
   end
`else
   // Single entry: a draining slot can be refilled in the same cycle.
   assign w_in_ready = ~r_mv | bus.out_ready;

   // Main entry: payload loads only on accept so idle cycles do not toggle it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mv    <= 1'b0;
         r_mdata <= '0;
         r_mctrl <= '0;
      end else if (bus.flush) begin
         r_mv <= 1'b0;
      end else if (!r_mv || w_drain) begin
         r_mv <= bus.in_valid;
         if (w_accept) begin
            r_mdata <= bus.in_data;
            r_mctrl <= bus.in_ctrl;
         end
      end
   end
`endif

   // Saturating back-pressure counter; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_mv;
   assign bus.out_data  = r_mdata;
   assign bus.out_ctrl  = r_mv ? r_mctrl : '0;
   assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, back-pressure, flush,
// bubble gating, counter saturation (CNT_W=4 instance) and async reset.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.DATA_W(48), .CTRL_W(7), .CNT_W(16)) bm ();
   pipe_stage_reg_if #(.DATA_W(8),  .CTRL_W(2), .CNT_W(4))  bs ();

   pipe_stage_reg #(.DATA_W(48), .CTRL_W(7), .CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bm)
   );

   pipe_stage_reg #(.DATA_W(8), .CTRL_W(2), .CNT_W(4)) dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bs)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [47:0] items [3];
      logic [47:0] rx [$];
      int          sent;
      logic        acc;
      logic        seen;

      items[0] = 48'h00AA;
      items[1] = 48'h00BB;
      items[2] = 48'h00CC;

      // reset held with a valid input present
      rst_n        = 1'b0;
      bm.in_valid  = 1'b1;
      bm.in_data   = 48'h1234;
      bm.in_ctrl   = 7'h55;
      bm.flush     = 1'b0;
      bm.out_ready = 1'b1;
      bs.in_valid  = 1'b0;
      bs.in_data   = '0;
      bs.in_ctrl   = '0;
      bs.flush     = 1'b0;
      bs.out_ready = 1'b0;
      repeat (3) tick();
      chk("rst_out_valid", bm.out_valid, 0);
      chk("rst_out_data",  bm.out_data,  0);
      chk("rst_out_ctrl",  bm.out_ctrl,  0);
      chk("rst_stall_cnt", bm.stall_cnt, 0);
      chk("rst_in_ready",  bm.in_ready,  1);

      rst_n = 1'b1;
      tick();
      chk("first_valid", bm.out_valid, 1);
      chk("first_data",  bm.out_data,  48'h1234);
      chk("first_ctrl",  bm.out_ctrl,  7'h55);

      // streaming 1..8 at full rate
      for (int i = 1; i <= 8; i++) begin
         bm.in_data = 48'(i);
         bm.in_ctrl = 7'(i);
         tick();
         chk("stream_valid", bm.out_valid, 1);
         chk("stream_data",  bm.out_data,  64'(i));
      end
      bm.in_valid = 1'b0;
      tick();
      chk("stream_end_valid", bm.out_valid, 0);
      chk("stream_end_ctrl",  bm.out_ctrl,  0);
      chk("stream_stall",     bm.stall_cnt, 0);

      // back-pressure: A, B, C with out_ready low
      bm.out_ready = 1'b0;
      bm.in_valid  = 1'b1;
      bm.in_ctrl   = 7'h11;
      bm.in_data   = items[0];
      #1;
      chk("bp_ready_c1", bm.in_ready, 1);
      tick();
      bm.in_data = items[1];
      #1;
`ifdef PIPE_STAGE_SKID_EN
      chk("bp_ready_c2", bm.in_ready, 1);
`else
      chk("bp_ready_c2", bm.in_ready, 0);
`endif
      tick();
      bm.in_data = items[2];
      #1;
      chk("bp_ready_c3", bm.in_ready, 0);
      tick();
      chk("bp_hold_data",  bm.out_data,  48'h00AA);
      chk("bp_hold_ctrl",  bm.out_ctrl,  7'h11);
      chk("bp_ready_held", bm.in_ready,  0);
      chk("bp_stall",      bm.stall_cnt, 2);

`ifdef PIPE_STAGE_SKID_EN
      sent = 2;
`else
      sent = 1;
`endif
      bm.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bm.in_valid = (sent < 3);
         bm.in_data  = (sent < 3) ? items[sent] : 48'h0;
         #1;
         if (bm.out_valid) rx.push_back(bm.out_data);
         acc = bm.in_valid & bm.in_ready;
         tick();
         if (acc) sent++;
      end
      bm.in_valid = 1'b0;
      chk("bp_sent",      32'(sent),    3);
      chk("bp_rx_count",  32'(rx.size()), 3);
      if (rx.size() == 3) begin
         chk("bp_rx0", rx[0], 48'h00AA);
         chk("bp_rx1", rx[1], 48'h00BB);
         chk("bp_rx2", rx[2], 48'h00CC);
      end
      chk("bp_stall_after", bm.stall_cnt, 2);

      // flush with main (and skid) full and a simultaneous accept
      bm.out_ready = 1'b0;
      bm.in_valid  = 1'b1;
      bm.in_ctrl   = 7'h22;
      bm.in_data   = 48'h0D0D;
      tick();
      bm.in_data = 48'h0E0E;
      tick();
      chk("fl_main_data", bm.out_data, 48'h0D0D);
      bm.flush   = 1'b1;
      bm.in_data = 48'h0F0F;
      bm.in_ctrl = 7'h03;
      #1;
      chk("fl_ready_rule", bm.in_ready, 0);
      tick();
      bm.flush    = 1'b0;
      bm.in_valid = 1'b0;
      chk("fl_out_valid", bm.out_valid, 0);
      chk("fl_out_ctrl",  bm.out_ctrl,  0);
      chk("fl_stall",     bm.stall_cnt, 4);
      chk("fl_in_ready",  bm.in_ready,  1);
      bm.out_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (bm.out_valid) seen = 1'b1;
      end
      chk("fl_nothing_out", seen, 0);

      // bubble gating of control payload
      bm.out_ready = 1'b0;
      bm.in_valid  = 1'b1;
      bm.in_data   = 48'hBEEF;
      bm.in_ctrl   = 7'h7F;
      tick();
      chk("bub_loaded_ctrl", bm.out_ctrl, 7'h7F);
      bm.in_valid  = 1'b0;
      bm.out_ready = 1'b1;
      tick();
      chk("bub_valid", bm.out_valid, 0);
      chk("bub_ctrl",  bm.out_ctrl,  0);
      chk("bub_stall", bm.stall_cnt, 4);

      // saturation on the CNT_W=4 instance
      bs.in_valid = 1'b1;
      bs.in_data  = 8'hA5;
      bs.in_ctrl  = 2'b11;
      tick();
      bs.in_valid = 1'b0;
      chk("sat_loaded", bs.out_valid, 1);
      repeat (5) tick();
      chk("sat_stall5", bs.stall_cnt, 5);
      repeat (15) tick();
      chk("sat_stall20", bs.stall_cnt, 15);
      chk("sat_data",    bs.out_data,  8'hA5);
      tick();
      chk("sat_stays",   bs.stall_cnt, 15);
      bs.flush = 1'b1;
      tick();
      bs.flush = 1'b0;
      chk("sat_flush_cnt",   bs.stall_cnt, 15);
      chk("sat_flush_valid", bs.out_valid, 0);

      // asynchronous reset mid-transfer
      bm.out_ready = 1'b0;
      bm.in_valid  = 1'b1;
      bm.in_data   = 48'h0077;
      bm.in_ctrl   = 7'h44;
      tick();
      tick();
      chk("ar_pre_stall", bm.stall_cnt, 5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", bm.out_valid, 0);
      chk("ar_out_data",  bm.out_data,  0);
      chk("ar_out_ctrl",  bm.out_ctrl,  0);
      chk("ar_stall",     bm.stall_cnt, 0);
      chk("ar_sat_stall", bs.stall_cnt, 0);
      bm.in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
